ab_gen: RTL and testbench
=========================

AB_GEN -- requirements
Module: ab_gen

Interface
REQ-001 SHALL have parameter AW, default 16, address bus width (16..24).
REQ-002 SHALL have parameter DW, default 8, data/index width; AW SHALL be at least 2*DW.
REQ-003 SHALL have parameter SP_PAGE, default 'h01, upper address bits prepended to SP for stack accesses.
REQ-004 SHALL have port clk, input, 1, single clock; all state SHALL update on posedge clk.
REQ-005 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port RDY, input, 1; low = stall, all state held.
REQ-007 SHALL have port op, input, 4, address operation (codes from shared package).
REQ-008 SHALL have port DI, input, DW, data bus in (operand bytes, pulled stack data).
REQ-009 SHALL have port IDX, input, DW, index/offset (X/Y or branch displacement).
REQ-010 SHALL have port AB, output, AW, registered address bus.
REQ-011 SHALL have port PC, output, AW, registered program counter.
REQ-012 SHALL have port SP, output, DW, registered stack pointer.
REQ-013 SHALL have port FIX, output, 1; high while in FIX state (page-fix cycle in progress; control must stall its sequencer).

Function
REQ-014 SHALL hold internal AHL (DW bits); AB_LDLO: AHL<=DI, AB<=PC, PC<=PC+1.
REQ-015 SHALL implement AB_FETCH: AB<=PC, PC<=PC+1, wrap modulo 2^AW.
REQ-016 SHALL implement AB_ABS: AB<={DI,AHL} zero-extended to AW; PC<=PC+1.
REQ-017 SHALL implement AB_ABSX: effective {DI,AHL}+IDX (IDX zero-extended), PC<=PC+1.
REQ-018 SHALL implement AB_ZPX: AB<=(AHL+IDX) mod 2^DW; no page carry, never enters FIX.
REQ-019 SHALL implement AB_BRA: effective PC+sign-extended IDX; PC<=effective address.
REQ-020 SHALL implement AB_PUSH: AB<={SP_PAGE,SP}, SP<=SP-1 (post-decrement, wraps 'h00->'hFF).
REQ-021 SHALL implement AB_PULL: SP<=SP+1, AB<={SP_PAGE,SP+1} (pre-increment, wraps).
REQ-022 SHALL implement AB_TXS: SP<=IDX; AB held.
REQ-023 SHALL implement AB_VEC0/1/2: AB<=all-ones upper bits with low byte 'hFA/'hFC/'hFE; PC held.
REQ-024 SHALL implement AB_HOLD: AB, PC, SP unchanged (read-modify-write).
REQ-025 SHALL treat undefined op codes as AB_HOLD.
REQ-026 SHALL have two states: IDLE, FIX; IDLE->FIX only as per REQ-031; FIX->IDLE after one RDY-qualified cycle.
REQ-027 SHALL in FIX: AB upper AW-DW bits <= AB upper + carry (+1, or -1 for negative branch); low byte unchanged; op ignored.
REQ-028 SHALL, when RDY low, hold AB, PC, SP, AHL, state and FIX; RST overrides RDY.

Reset
REQ-029 SHALL on RST: AB<=all-ones with low byte 'hFC, PC<=0, SP<='hFF, AHL<=0, state<=IDLE, FIX<=0.
REQ-030 SHALL on RST during FIX abandon the fix-up; next cycle IDLE.

Configuration
REQ-031 SHALL with AB_PAGE_FIX_EN defined: AB_ABSX/AB_BRA crossing a DW-page issue AB with uncorrected upper bits (low byte correct) and enter FIX; no crossing -> final address in one cycle, stay IDLE.
REQ-032 SHALL without AB_PAGE_FIX_EN: AB_ABSX/AB_BRA compute full-width sum in one cycle; FIX constant 0, FIX state unreachable.

Structure
REQ-033 SHALL place op encodings (AB_*) and state encoding in shared package ab_pkg.
REQ-034 SHALL use one sub-module ab_add: DW-bit adder, inputs base, offset, carry-in; outputs sum, carry-out.

Verification
REQ-035 SHALL test reset: RST 1 cycle -> AB='hFFFC, PC=0, SP='hFF, FIX=0.
REQ-036 SHALL test AB_LDLO DI='h34 then AB_ABSX DI='h12, IDX='hF0 -> with macro AB='h1224, FIX=1, next AB='h1324; without macro AB='h1324, FIX=0.
REQ-037 SHALL test PC='h2005, AB_BRA IDX='hF0 -> with macro AB='h20F5 then 'h1FF5; PC='h1FF5.
REQ-038 SHALL test AB_TXS IDX='h00, AB_PUSH -> AB='h0100, SP='hFF; AB_PULL -> AB='h0100, SP='h00.
REQ-039 SHALL test RDY low during FIX holds AB/FIX; RST asserted in FIX -> IDLE, FIX=0 next cycle.
REQ-040 SHALL test PC='hFFFF, AB_FETCH -> AB='hFFFF, PC='h0000.

Source files
------------

// File: rtl/ab_pkg.sv
// Shared definitions for the address-bus generator: operation codes,
// controller state encoding and vector low-byte lookup.
package ab_pkg;

    typedef enum logic [3:0] {
        AB_HOLD  = 4'd0,
        AB_LDLO  = 4'd1,
        AB_FETCH = 4'd2,
        AB_ABS   = 4'd3,
        AB_ABSX  = 4'd4,
        AB_ZPX   = 4'd5,
        AB_BRA   = 4'd6,
        AB_PUSH  = 4'd7,
        AB_PULL  = 4'd8,
        AB_TXS   = 4'd9,
        AB_VEC0  = 4'd10,
        AB_VEC1  = 4'd11,
        AB_VEC2  = 4'd12
    } ab_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FIX  = 1'b1
    } ab_state_e;

    localparam logic [7:0] RST_VEC_LO = 8'hFC;

    // Low byte of the vector address selected by a vector op.
    function automatic logic [7:0] vec_lo(input logic [3:0] op);
        case (op)
            AB_VEC0: return 8'hFA;
            AB_VEC1: return 8'hFC;
            default: return 8'hFE;
        endcase
    endfunction

endpackage

// File: rtl/ab_gen_add.sv
// DW-bit adder with carry in/out, shared by the indexed, zero-page and
// branch address computations.
module ab_add #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] base,
    input  logic [DW-1:0] offset,
    input  logic          cin,
    output logic [DW-1:0] sum,
    output logic          cout
);

    // Carry-out is the bit above the DW-bit sum.
    assign {cout, sum} = {1'b0, base} + {1'b0, offset} + {{DW{1'b0}}, cin};

endmodule

// File: rtl/ab_gen.sv
// Address-bus generator: program counter, stack pointer and address bus
// sequencing with an optional page-fix cycle for indexed/branch crossings.
// Optional feature macro: AB_PAGE_FIX_EN (adds the one-cycle page fix-up).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | normal operation, op decoded every RDY cycle
// ST_FIX  | page-fix cycle: AB upper bits corrected by +1/-1, op ignored
module ab_gen
    import ab_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int SP_PAGE = 'h01
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          RDY,
    input  logic [3:0]    op,
    input  logic [DW-1:0] DI,
    input  logic [DW-1:0] IDX,
    output logic [AW-1:0] AB,
    output logic [AW-1:0] PC,
    output logic [DW-1:0] SP,
    output logic          FIX
);

    localparam int UW = AW - DW;
    localparam logic [UW-1:0] SP_HI = UW'(SP_PAGE);
`ifdef AB_PAGE_FIX_EN
    localparam bit PAGE_FIX = 1'b1;
`else
    localparam bit PAGE_FIX = 1'b0;
`endif

    ab_state_e     state, state_nxt;
    logic [DW-1:0] ahl, ahl_nxt;
    logic [DW-1:0] sp_nxt;
    logic [AW-1:0] ab_nxt, pc_nxt;
    logic          fix_dec, fix_dec_nxt;

    logic [DW-1:0] add_base, add_sum;
    logic          add_co;
    logic [UW-1:0] ab_hi, pc_hi, di_hi, absx_hi, bra_hi;
    logic          idx_neg, absx_cross, bra_cross;

    assign add_base = (op == AB_BRA) ? PC[DW-1:0] : ahl;

    ab_add #(.DW(DW)) u_add (
        .base   (add_base),
        .offset (IDX),
        .cin    (1'b0),
        .sum    (add_sum),
        .cout   (add_co)
    );

    assign ab_hi   = AB[AW-1:DW];
    assign pc_hi   = PC[AW-1:DW];
    assign di_hi   = UW'(DI);
    assign idx_neg = IDX[DW-1];

    // Upper-part of the effective address; a branch back with no carry
    // borrows from the page, a branch forward with carry moves up one.
    assign absx_hi    = di_hi + UW'(add_co);
    assign bra_hi     = pc_hi + UW'(add_co) - UW'(idx_neg);
    assign absx_cross = add_co;
    assign bra_cross  = add_co ^ idx_neg;

`ifdef AB_PAGE_FIX_EN
    assign FIX = (state == ST_FIX);
`else
    assign FIX = 1'b0;
`endif

    // Next-state and next-register values for the current op/state.
    always_comb begin
        state_nxt   = state;
        ab_nxt      = AB;
        pc_nxt      = PC;
        sp_nxt      = SP;
        ahl_nxt     = ahl;
        fix_dec_nxt = fix_dec;
        case (state)
            ST_FIX: begin
                ab_nxt    = {(fix_dec ? ab_hi - UW'(1) : ab_hi + UW'(1)), AB[DW-1:0]};
                state_nxt = ST_IDLE;
            end
            default: begin
                case (op)
                    AB_LDLO: begin
                        ahl_nxt = DI;
                        ab_nxt  = PC;
                        pc_nxt  = PC + AW'(1);
                    end
                    AB_FETCH: begin
                        ab_nxt = PC;
                        pc_nxt = PC + AW'(1);
                    end
                    AB_ABS: begin
                        ab_nxt = {di_hi, ahl};
                        pc_nxt = PC + AW'(1);
                    end
                    AB_ABSX: begin
                        pc_nxt = PC + AW'(1);
                        if (PAGE_FIX && absx_cross) begin
                            ab_nxt      = {di_hi, add_sum};
                            state_nxt   = ST_FIX;
                            fix_dec_nxt = 1'b0;
                        end else begin
                            ab_nxt = {absx_hi, add_sum};
                        end
                    end
                    AB_ZPX: begin
                        ab_nxt = AW'(add_sum);
                    end
                    AB_BRA: begin
                        pc_nxt = {bra_hi, add_sum};
                        if (PAGE_FIX && bra_cross) begin
                            ab_nxt      = {pc_hi, add_sum};
                            state_nxt   = ST_FIX;
                            fix_dec_nxt = idx_neg;
                        end else begin
                            ab_nxt = {bra_hi, add_sum};
                        end
                    end
                    AB_PUSH: begin
                        ab_nxt = {SP_HI, SP};
                        sp_nxt = SP - DW'(1);
                    end
                    AB_PULL: begin
                        sp_nxt = SP + DW'(1);
                        ab_nxt = {SP_HI, SP + DW'(1)};
                    end
                    AB_TXS: begin
                        sp_nxt = IDX;
                    end
                    AB_VEC0, AB_VEC1, AB_VEC2: begin
                        ab_nxt = {{(AW-8){1'b1}}, vec_lo(op)};
                    end
                    default: ;
                endcase
            end
        endcase
    end

    // Register update: reset wins, RDY low freezes everything.
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= ST_IDLE;
            AB      <= {{(AW-8){1'b1}}, RST_VEC_LO};
            PC      <= '0;
            SP      <= '1;
            ahl     <= '0;
            fix_dec <= 1'b0;
        end else if (RDY) begin
            state   <= state_nxt;
            AB      <= ab_nxt;
            PC      <= pc_nxt;
            SP      <= sp_nxt;
            ahl     <= ahl_nxt;
            fix_dec <= fix_dec_nxt;
        end
    end

endmodule

// File: tb/tb_ab_gen.sv
// Self-checking bench for ab_gen: directed literal cases plus randomized
// ops against an arithmetic reference model. Follows AB_PAGE_FIX_EN.
module tb_ab_gen;
    import ab_pkg::*;

`ifdef AB_PAGE_FIX_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk;
    logic        RST, RDY;
    logic [3:0]  op;
    logic [7:0]  DI, IDX;
    logic [15:0] AB, PC;
    logic [7:0]  SP;
    logic        FIX;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // reference model state
    int m_ab, m_pc, m_sp, m_ahl, m_tgt;
    bit m_fix;

    ab_gen #(.AW(16), .DW(8), .SP_PAGE('h01)) dut (
        .clk (clk), .RST (RST), .RDY (RDY), .op (op), .DI (DI), .IDX (IDX),
        .AB  (AB),  .PC  (PC),  .SP  (SP),  .FIX (FIX)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit rdy, input int o, input int d, input int x);
        int eff, off, old_pc;
        if (r) begin
            m_ab = 'hFFFC; m_pc = 0; m_sp = 'hFF; m_ahl = 0; m_fix = 0;
        end else if (!rdy) begin
        end else if (m_fix) begin
            m_ab  = m_tgt;
            m_fix = 0;
        end else begin
            case (o)
                AB_LDLO:  begin m_ahl = d; m_ab = m_pc; m_pc = (m_pc + 1) & 'hFFFF; end
                AB_FETCH: begin m_ab = m_pc; m_pc = (m_pc + 1) & 'hFFFF; end
                AB_ABS:   begin m_ab = d * 256 + m_ahl; m_pc = (m_pc + 1) & 'hFFFF; end
                AB_ABSX: begin
                    eff  = (d * 256 + m_ahl + x) & 'hFFFF;
                    m_pc = (m_pc + 1) & 'hFFFF;
                    if (PF && (eff >> 8) != d) begin
                        m_ab = d * 256 + (eff & 'hFF); m_fix = 1; m_tgt = eff;
                    end else m_ab = eff;
                end
                AB_ZPX: m_ab = (m_ahl + x) & 'hFF;
                AB_BRA: begin
                    off    = (x >= 128) ? x - 256 : x;
                    old_pc = m_pc;
                    eff    = (m_pc + off + 65536) & 'hFFFF;
                    m_pc   = eff;
                    if (PF && (eff >> 8) != (old_pc >> 8)) begin
                        m_ab = (old_pc & 'hFF00) | (eff & 'hFF); m_fix = 1; m_tgt = eff;
                    end else m_ab = eff;
                end
                AB_PUSH: begin m_ab = 256 + m_sp; m_sp = (m_sp - 1) & 'hFF; end
                AB_PULL: begin m_sp = (m_sp + 1) & 'hFF; m_ab = 256 + m_sp; end
                AB_TXS:  m_sp = x;
                AB_VEC0: m_ab = 'hFFFA;
                AB_VEC1: m_ab = 'hFFFC;
                AB_VEC2: m_ab = 'hFFFE;
                default: ;
            endcase
        end
    endtask

    // Apply inputs, clock once, advance the model, settle past the edge.
    task automatic cycle(input bit r, input bit rdy, input logic [3:0] o, input logic [7:0] d, input logic [7:0] x);
        RST = r; RDY = rdy; op = o; DI = d; IDX = x;
        @(posedge clk);
        model_step(r, rdy, int'(o), int'(d), int'(x));
        #1;
    endtask

    task automatic settle();
        int n = 0;
        while (FIX === 1'b1 && n < 4) begin
            cycle(0, 1, AB_HOLD, 8'h00, 8'h00);
            n++;
        end
        chk("fix_settle", FIX, 0);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] d, input logic [7:0] x);
        cycle(0, 1, o, d, x);
        settle();
    endtask

    // Every-cycle comparison against the reference model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("AB", AB, m_ab);
            chk("PC", PC, m_pc);
            chk("SP", SP, m_sp);
            chk("FIX", FIX, m_fix);
        end
    end

    initial begin
        RST = 1; RDY = 1; op = AB_HOLD; DI = 0; IDX = 0;
        m_ab = 0; m_pc = 0; m_sp = 0; m_ahl = 0; m_tgt = 0; m_fix = 0;

        cycle(1, 1, AB_HOLD, 8'h00, 8'h00);
        chk_en = 1;
        chk("rst_AB", AB, 'hFFFC);
        chk("rst_PC", PC, 'h0000);
        chk("rst_SP", SP, 'hFF);
        chk("rst_FIX", FIX, 0);

        cycle(0, 1, AB_LDLO, 8'h34, 8'h00);
        chk("ldlo_AB", AB, 'h0000);
        chk("ldlo_PC", PC, 'h0001);
        cycle(0, 1, AB_ABSX, 8'h12, 8'hF0);
`ifdef AB_PAGE_FIX_EN
        chk("absx_AB1", AB, 'h1224);
        chk("absx_FIX1", FIX, 1);
        cycle(0, 1, AB_HOLD, 8'h00, 8'h00);
`endif
        chk("absx_AB", AB, 'h1324);
        chk("absx_FIX", FIX, 0);
        chk("absx_PC", PC, 'h0002);

        cycle(0, 1, AB_ZPX, 8'h00, 8'hF0);
        chk("zpx_AB", AB, 'h0024);
        cycle(0, 1, AB_VEC0, 8'h00, 8'h00);
        chk("vec0_AB", AB, 'hFFFA);
        cycle(0, 1, AB_VEC2, 8'h00, 8'h00);
        chk("vec2_AB", AB, 'hFFFE);

        cycle(0, 1, AB_TXS, 8'h00, 8'h00);
        chk("txs_SP", SP, 'h00);
        chk("txs_AB", AB, 'hFFFE);
        cycle(0, 1, AB_PUSH, 8'h00, 8'h00);
        chk("push_AB", AB, 'h0100);
        chk("push_SP", SP, 'hFF);
        cycle(0, 1, AB_PULL, 8'h00, 8'h00);
        chk("pull_AB", AB, 'h0100);
        chk("pull_SP", SP, 'h00);

        cycle(1, 1, AB_HOLD, 8'h00, 8'h00);
        do_op(AB_BRA, 8'h00, 8'hFF);
        chk("bra_back_PC", PC, 'hFFFF);
        cycle(0, 1, AB_FETCH, 8'h00, 8'h00);
        chk("fetch_wrap_AB", AB, 'hFFFF);
        chk("fetch_wrap_PC", PC, 'h0000);

        cycle(1, 1, AB_HOLD, 8'h00, 8'h00);
        for (int i = 0; i < 64; i++) do_op(AB_BRA, 8'h00, 8'h7F);
        do_op(AB_BRA, 8'h00, 8'h45);
        chk("bra_climb_PC", PC, 'h2005);
        cycle(0, 1, AB_BRA, 8'h00, 8'hF0);
`ifdef AB_PAGE_FIX_EN
        chk("bra_AB1", AB, 'h20F5);
        chk("bra_FIX1", FIX, 1);
        cycle(0, 1, AB_HOLD, 8'h00, 8'h00);
`endif
        chk("bra_AB", AB, 'h1FF5);
        chk("bra_PC", PC, 'h1FF5);

        cycle(0, 0, AB_FETCH, 8'h00, 8'h00);
        chk("rdy_hold_PC", PC, 'h1FF5);
        chk("rdy_hold_AB", AB, 'h1FF5);

`ifdef AB_PAGE_FIX_EN
        cycle(0, 1, AB_LDLO, 8'h34, 8'h00);
        cycle(0, 1, AB_ABSX, 8'h12, 8'hF0);
        cycle(0, 0, AB_FETCH, 8'h00, 8'h00);
        cycle(0, 0, AB_FETCH, 8'h00, 8'h00);
        chk("fix_stall_AB", AB, 'h1224);
        chk("fix_stall_FIX", FIX, 1);
`endif
        cycle(1, 0, AB_HOLD, 8'h00, 8'h00);
        chk("rst_over_rdy_AB", AB, 'hFFFC);
        chk("rst_over_rdy_FIX", FIX, 0);
        cycle(0, 1, AB_FETCH, 8'h00, 8'h00);
        chk("post_rst_AB", AB, 'h0000);
        chk("post_rst_FIX", FIX, 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
